uart_rx_frame_ctrl: RTL and testbench
=====================================

# uart_rx_frame_ctrl

Frame controller behind the UART receiver. It consumes the receiver's byte/done stream, finds framed commands (sync, address, length, payload, checksum) and buffers the payload. Only after the frame validates does it replay the payload as a burst of register writes. It is the single point that turns raw serial bytes into configuration-bus traffic.

## Interface
Parameters:
- MAX_LEN, 16: maximum payload bytes per frame (2..64).
- TIMEOUT_CYC, 2048: inter-byte timeout, in rx_clk cycles (16x baud clock).

Ports:
- rx_clk  in  1  16x baud clock, same clock as the receiver.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- rx_data  in  8  received byte, valid when rx_done is high.
- rx_done  in  1  one-cycle byte strobe from the receiver.
- wr_en  out  1  write request. Held until accepted.
- wr_addr  out  8  write address.
- wr_data  out  8  write data.
- wr_ready  in  1  write accept. A transfer occurs on any cycle with wr_en && wr_ready.
- frame_ok  out  1  one-cycle pulse when a frame has been fully committed.
- frame_err  out  1  one-cycle pulse when a frame is aborted.
- err_code  out  2  0 = checksum, 1 = bad length, 2 = timeout, 3 = overrun. Valid with frame_err; holds its last value otherwise.
- busy  out  1  high in every state except HUNT.

## Operation
- Frame format: 0xA5, ADDR, LEN, LEN payload bytes, CHK.
  - CHK = ADDR ^ LEN ^ all payload bytes.
- States: HUNT, ADDR, LEN, DATA, CHK, COMMIT.
- HUNT: on rx_done with 0xA5, go to ADDR. Any other byte is ignored silently.
- ADDR: latch the base address, go to LEN.
- LEN:
  - LEN == 0 or LEN > MAX_LEN: frame_err, code 1, go to HUNT.
  - Otherwise go to DATA with index = 0.
- DATA: write each byte to buffer[index]. After the LEN-th byte, go to CHK.
- CHK:
  - Byte equals the running XOR: go to COMMIT.
  - Otherwise: frame_err, code 0, go to HUNT. The buffer contents are discarded.
- COMMIT: replay the payload in order.
  - wr_addr = ADDR + i, modulo 256 (the address wraps 0xFF -> 0x00).
  - wr_data = buffer[i].
  - After the final accepted write: frame_ok, go to HUNT.
- Timeout: in ADDR, LEN, DATA or CHK, a counter clears on each rx_done. When it reaches TIMEOUT_CYC-1: frame_err, code 2, go to HUNT.
- Overrun: rx_done during COMMIT drops the byte and pulses frame_err with code 3. The commit itself continues to completion, and frame_ok still pulses at the end.
- If frame_ok and an overrun frame_err fall in the same cycle, both pulse; err_code = 3.
- Reset mid-frame (asynchronous): all state is abandoned and no partial writes are issued afterwards. Writes accepted before reset stand.
- Reset values: state HUNT, wr_en 0, wr_addr 0, wr_data 0, frame_ok 0, frame_err 0, err_code 0, busy 0. Index, checksum and timeout counter reset to 0.

## Timing
- All outputs are registered.
- Byte parsing: the state update is visible the cycle after the rx_done edge.
- Commit start: wr_en rises the cycle after the rx_done carrying a valid CHK. wr_addr and wr_data are valid in that same cycle.
- Write handshake: wr_addr and wr_data must remain stable while wr_en && !wr_ready.
- Write throughput: with wr_ready held high, one write per cycle. A LEN-byte commit takes LEN cycles.
- Frame completion: in the cycle after the last accepted write, wr_en = 0, frame_ok = 1 and state = HUNT. busy falls in the same cycle.
- No combinational path from any input to any output.

## Configuration
- UART_RX_FRAME_CTRL_CHK_EN defined:
  - The CHK byte is expected and verified, as described above.
- Undefined:
  - There is no CHK state; COMMIT is entered the cycle after the last payload byte.
  - Error code 0 never occurs.
  - The frame is one byte shorter (no CHK byte).

## Structure
- Shared package uart_pkg holds:
  - UART_SYNC_BYTE = 8'hA5.
  - The frame-state enum.
  - The err_code enum (ERR_CHK, ERR_LEN, ERR_TIMEOUT, ERR_OVERRUN).
- Sub-module uart_frame_buf: a MAX_LEN x 8 register file with synchronous write port and combinational read port, indexed by a $clog2(MAX_LEN)-bit pointer.

## Test plan
- Valid frame, CHK enabled, wr_ready = 1: A5 10 03 11 22 33 CHK = 0x10 ^ 0x03 ^ 0x11 ^ 0x22 ^ 0x33 = 0x13 -> writes (10,11) (11,22) (12,33) on consecutive cycles, then frame_ok; no frame_err.
- Same frame with CHK = 0x14 -> frame_err with code 0; no wr_en.
- A5 20 00 -> frame_err code 1. A5 20 11 with MAX_LEN = 16 -> frame_err code 1.
- A5 FE 02 AA BB with valid CHK -> writes to FE then FF. Then stall wr_ready low for 5 cycles mid-commit -> wr_addr and wr_data held stable during the stall.
- A5 40 then silence for TIMEOUT_CYC cycles -> frame_err code 2 and state HUNT. A following valid frame is accepted normally.
- rx_done arriving during a stalled commit -> frame_err code 3; the commit finishes with frame_ok. rst_n asserted mid-DATA -> all outputs return to reset values immediately and no writes follow.

Source files
------------

// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared types for the UART frame controller.
// Sync byte, frame-state enum, error-code enum.
package uart_pkg;

  localparam logic [7:0] UART_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_COMMIT
  } frame_st_e;

  typedef enum logic [1:0] {
    ERR_CHK     = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_code_e;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Register-write bus: wr_en/wr_addr/wr_data held until wr_ready.
// master drives the request, slave returns wr_ready.
interface uart_rx_frame_ctrl_if;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (
    output wr_en, wr_addr, wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    output wr_ready
  );
endinterface

// File: rtl/uart_rx_frame_ctrl_buf.sv
// uart_frame_buf: MAX_LEN x 8 payload store.
// Ports: i_clk, i_we/i_wptr/i_wdata (sync write), i_rptr/o_rdata (comb read).
module uart_frame_buf #(
  parameter int MAX_LEN = 16,
  parameter int PW      = $clog2(MAX_LEN)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [PW-1:0] i_wptr,
  input  logic [7:0]    i_wdata,
  input  logic [PW-1:0] i_rptr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [MAX_LEN];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_rptr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame parser: A5, ADDR, LEN, payload, [CHK] -> burst of register writes.
// Ports: rx_clk, rst_n, rx_data/rx_done in; wr bus (master);
// frame_ok, frame_err, err_code, busy out.
// Define UART_RX_FRAME_CTRL_CHK_EN to expect and verify the CHK byte.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 2048
) (
  input  logic       rx_clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  uart_rx_frame_ctrl_if.master wr,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int PW = $clog2(MAX_LEN);
  localparam int IW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  frame_st_e     r_state, w_nxt;
  logic [IW-1:0] r_idx, w_idx;
  logic [7:0]    r_len, w_len;
  logic [7:0]    r_addr, w_addr;
`ifdef UART_RX_FRAME_CTRL_CHK_EN
  logic [7:0]    r_chk, w_chk;
`endif
  logic [TW-1:0] r_tmo, w_tmo;
  logic          r_wr_en, w_wr_en;
  logic [7:0]    r_wr_addr, w_wr_addr;
  logic [7:0]    r_wr_data, w_wr_data;
  logic          r_ok, w_ok;
  logic          r_err, w_err;
  err_code_e     r_code, w_code;

  logic          w_buf_we;
  logic          w_start;
  logic          w_last;
  logic          w_wait;
  logic [PW-1:0] w_rd_ptr;
  logic [7:0]    w_rd_data;
  logic [7:0]    w_first;

  // In COMMIT the read port looks one entry ahead so the
  // next write's data is ready when the current one is accepted.
  assign w_rd_ptr = (r_state == ST_COMMIT) ?
                    r_idx[PW-1:0] + PW'(1) : '0;
  assign w_last   = (8'(r_idx) == r_len - 8'd1);
  assign w_wait   = r_state inside
                    {ST_ADDR, ST_LEN, ST_DATA, ST_CHK};

`ifdef UART_RX_FRAME_CTRL_CHK_EN
  assign w_first = w_rd_data;
`else
  // Commit starts on the last payload byte; with LEN == 1
  // that byte is entry 0 and is not in the buffer yet.
  assign w_first = (r_idx == '0) ? rx_data : w_rd_data;
`endif

  uart_frame_buf #(.MAX_LEN(MAX_LEN)) u_buf (
    .i_clk  (rx_clk),
    .i_we   (w_buf_we),
    .i_wptr (r_idx[PW-1:0]),
    .i_wdata(rx_data),
    .i_rptr (w_rd_ptr),
    .o_rdata(w_rd_data)
  );

  always_comb begin
    w_nxt     = r_state;
    w_idx     = r_idx;
    w_len     = r_len;
    w_addr    = r_addr;
`ifdef UART_RX_FRAME_CTRL_CHK_EN
    w_chk     = r_chk;
`endif
    w_tmo     = r_tmo;
    w_wr_en   = r_wr_en;
    w_wr_addr = r_wr_addr;
    w_wr_data = r_wr_data;
    w_ok      = 1'b0;
    w_err     = 1'b0;
    w_code    = r_code;
    w_buf_we  = 1'b0;
    w_start   = 1'b0;

    if (w_wait) begin
      if (rx_done) begin
        w_tmo = '0;
      end else if (r_tmo == TMAX) begin
        w_tmo  = '0;
        w_err  = 1'b1;
        w_code = ERR_TIMEOUT;
        w_nxt  = ST_HUNT;
      end else begin
        w_tmo = r_tmo + TW'(1);
      end
    end

    unique case (r_state)
      ST_HUNT: begin
        if (rx_done && rx_data == UART_SYNC_BYTE) begin
          w_nxt = ST_ADDR;
          w_tmo = '0;
        end
      end
      ST_ADDR: begin
        if (rx_done) begin
          w_addr = rx_data;
`ifdef UART_RX_FRAME_CTRL_CHK_EN
          w_chk  = rx_data;
`endif
          w_nxt  = ST_LEN;
        end
      end
      ST_LEN: begin
        if (rx_done) begin
          w_len = rx_data;
          w_idx = '0;
`ifdef UART_RX_FRAME_CTRL_CHK_EN
          w_chk = r_chk ^ rx_data;
`endif
          if (rx_data == 8'd0 ||
              rx_data > 8'(MAX_LEN)) begin
            w_err  = 1'b1;
            w_code = ERR_LEN;
            w_nxt  = ST_HUNT;
          end else begin
            w_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (rx_done) begin
          w_buf_we = 1'b1;
`ifdef UART_RX_FRAME_CTRL_CHK_EN
          w_chk = r_chk ^ rx_data;
`endif
          if (w_last) begin
`ifdef UART_RX_FRAME_CTRL_CHK_EN
            w_nxt = ST_CHK;
`else
            w_start = 1'b1;
`endif
          end else begin
            w_idx = r_idx + IW'(1);
          end
        end
      end
`ifdef UART_RX_FRAME_CTRL_CHK_EN
      ST_CHK: begin
        if (rx_done) begin
          if (rx_data == r_chk) begin
            w_start = 1'b1;
          end else begin
            w_err  = 1'b1;
            w_code = ERR_CHK;
            w_nxt  = ST_HUNT;
          end
        end
      end
`endif
      ST_COMMIT: begin
        if (rx_done) begin
          w_err  = 1'b1;
          w_code = ERR_OVERRUN;
        end
        if (r_wr_en && wr.wr_ready) begin
          if (w_last) begin
            w_wr_en = 1'b0;
            w_ok    = 1'b1;
            w_nxt   = ST_HUNT;
          end else begin
            w_idx     = r_idx + IW'(1);
            w_wr_addr = r_wr_addr + 8'd1;
            w_wr_data = w_rd_data;
          end
        end
      end
      default: ;
    endcase

    if (w_start) begin
      w_nxt     = ST_COMMIT;
      w_idx     = '0;
      w_wr_en   = 1'b1;
      w_wr_addr = r_addr;
      w_wr_data = w_first;
    end
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_HUNT;
      r_idx     <= '0;
      r_len     <= '0;
      r_addr    <= '0;
`ifdef UART_RX_FRAME_CTRL_CHK_EN
      r_chk     <= '0;
`endif
      r_tmo     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_ok      <= 1'b0;
      r_err     <= 1'b0;
      r_code    <= ERR_CHK;
    end else begin
      r_state   <= w_nxt;
      r_idx     <= w_idx;
      r_len     <= w_len;
      r_addr    <= w_addr;
`ifdef UART_RX_FRAME_CTRL_CHK_EN
      r_chk     <= w_chk;
`endif
      r_tmo     <= w_tmo;
      r_wr_en   <= w_wr_en;
      r_wr_addr <= w_wr_addr;
      r_wr_data <= w_wr_data;
      r_ok      <= w_ok;
      r_err     <= w_err;
      r_code    <= w_code;
    end
  end

  assign wr.wr_en   = r_wr_en;
  assign wr.wr_addr = r_wr_addr;
  assign wr.wr_data = r_wr_data;
  assign frame_ok   = r_ok;
  assign frame_err  = r_err;
  assign err_code   = r_code;
  assign busy       = (r_state != ST_HUNT);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: frame-level model + scoreboard.
// Honours UART_RX_FRAME_CTRL_CHK_EN for the CHK byte.
module tb_uart_rx_frame_ctrl;

  localparam int ML = 16;
  localparam int TO = 64;
`ifdef UART_RX_FRAME_CTRL_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_done = 1'b0;
  logic       frame_ok, frame_err, busy;
  logic [1:0] err_code;

  uart_rx_frame_ctrl_if wr();

  uart_rx_frame_ctrl #(
    .MAX_LEN(ML),
    .TIMEOUT_CYC(TO)
  ) dut (
    .rx_clk   (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .wr       (wr.master),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_w[$];
  int          exp_err[$];
  int          exp_ok = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every write, error and ok pulse must match
  // what the frame model queued; stalled writes must hold.
  logic       p_stall = 1'b0;
  logic [7:0] p_a = '0, p_d = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall)
        chk("hold", {wr.wr_en, wr.wr_addr, wr.wr_data},
            {1'b1, p_a, p_d});
      if (wr.wr_en && wr.wr_ready) begin
        if (exp_w.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_extra act=%0h exp=none",
                   {wr.wr_addr, wr.wr_data});
        end else begin
          chk("wr", {wr.wr_addr, wr.wr_data},
              exp_w.pop_front());
        end
      end
      if (frame_err) begin
        if (exp_err.size() == 0) begin
          checks++; errors++;
          $display("FAIL err_extra act=%0d exp=none",
                   err_code);
        end else begin
          chk("err_code", err_code, exp_err.pop_front());
        end
      end
      if (frame_ok) begin
        checks++;
        if (exp_ok == 0) begin
          errors++;
          $display("FAIL ok_extra act=1 exp=0");
        end else begin
          exp_ok--;
        end
      end
      p_stall = wr.wr_en && !wr.wr_ready;
      p_a     = wr.wr_addr;
      p_d     = wr.wr_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  // Frame model: decide the outcome from the frame rules,
  // queue it, then shift the bytes in.
  task automatic send_frame(input logic [7:0] a,
                            input logic [7:0] len,
                            input bq_t pl,
                            input bit bad);
    logic [7:0] c;
    bit ok_len;
    c = a ^ len;
    foreach (pl[i]) c ^= pl[i];
    ok_len = (len != 0) && (len <= ML);
    if (!ok_len) exp_err.push_back(1);
    else if (CHK_EN && bad) exp_err.push_back(0);
    else begin
      foreach (pl[i])
        exp_w.push_back({8'(a + 8'(i)), pl[i]});
      exp_ok++;
    end
    send_byte(8'hA5);
    send_byte(a);
    send_byte(len);
    if (ok_len) begin
      foreach (pl[i]) send_byte(pl[i]);
      if (CHK_EN) send_byte(bad ? (c ^ 8'h07) : c);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy && exp_w.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("idle_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_wr_en"}, wr.wr_en, 0);
    chk({nm, "_addr"}, wr.wr_addr, 0);
    chk({nm, "_data"}, wr.wr_data, 0);
    chk({nm, "_ok"}, frame_ok, 0);
    chk({nm, "_err"}, frame_err, 0);
    chk({nm, "_code"}, err_code, 0);
    chk({nm, "_busy"}, busy, 0);
  endtask

  initial begin
    bq_t q;
    wr.wr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Stray byte in HUNT: ignored.
    send_byte(8'h3C);
    chk("hunt_busy", busy, 0);

    // Basic frame, back-to-back writes.
    q = {8'h11, 8'h22, 8'h33};
    send_frame(8'h10, 8'd3, q, 1'b0);
    chk("f1_en", wr.wr_en, 1);
    chk("f1_a0", wr.wr_addr, 8'h10);
    chk("f1_d0", wr.wr_data, 8'h11);
    chk("f1_busy", busy, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("f1_ok", frame_ok, 1);
    chk("f1_en_end", wr.wr_en, 0);
    chk("f1_busy_end", busy, 0);
    wait_idle();

`ifdef UART_RX_FRAME_CTRL_CHK_EN
    send_frame(8'h10, 8'd3, q, 1'b1);
    chk("badchk_err", frame_err, 1);
    chk("badchk_code", err_code, 0);
    chk("badchk_en", wr.wr_en, 0);
    wait_idle();
`endif

    // Length bounds.
    q = {};
    send_frame(8'h20, 8'h00, q, 1'b0);
    chk("len0_err", frame_err, 1);
    chk("len0_code", err_code, 1);
    send_frame(8'h20, 8'h11, q, 1'b0);
    chk("len17_err", frame_err, 1);
    chk("len17_code", err_code, 1);
    chk("len17_busy", busy, 0);

    // Address wrap, stall, overrun.
    wr.wr_ready = 1'b0;
    q = {8'hAA, 8'hBB};
    send_frame(8'hFE, 8'd2, q, 1'b0);
    chk("wrap_a0", wr.wr_addr, 8'hFE);
    chk("wrap_d0", wr.wr_data, 8'hAA);
    repeat (2) @(posedge clk);
    #1;
    wr.wr_ready = 1'b1;
    @(posedge clk); #1;
    wr.wr_ready = 1'b0;
    chk("wrap_a1", wr.wr_addr, 8'hFF);
    chk("wrap_d1", wr.wr_data, 8'hBB);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_en", wr.wr_en, 1);
    chk("stall_a1", wr.wr_addr, 8'hFF);
    exp_err.push_back(3);
    send_byte(8'h55);
    chk("ovr_err", frame_err, 1);
    chk("ovr_code", err_code, 3);
    chk("ovr_en", wr.wr_en, 1);
    wr.wr_ready = 1'b1;
    @(posedge clk); #1;
    chk("ovr_ok", frame_ok, 1);
    chk("ovr_busy", busy, 0);
    wait_idle();

    // Inter-byte timeout.
    exp_err.push_back(2);
    send_byte(8'hA5);
    send_byte(8'h40);
    repeat (TO - 1) @(posedge clk);
    #1;
    chk("tmo_early", frame_err, 0);
    chk("tmo_busy", busy, 1);
    @(posedge clk); #1;
    chk("tmo_err", frame_err, 1);
    chk("tmo_code", err_code, 2);
    chk("tmo_hunt", busy, 0);
    q = {8'h5A};
    send_frame(8'h30, 8'd1, q, 1'b0);
    wait_idle();

    // Reset in the middle of the payload.
    send_byte(8'hA5);
    send_byte(8'h50);
    send_byte(8'h04);
    send_byte(8'h01);
    send_byte(8'h02);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset("mrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("mrst_quiet", wr.wr_en, 0);

    // Boundaries: single byte at 0xFF, full MAX_LEN.
    q = {8'h77};
    send_frame(8'hFF, 8'd1, q, 1'b0);
    chk("one_a", wr.wr_addr, 8'hFF);
    chk("one_d", wr.wr_data, 8'h77);
    wait_idle();
    q = {};
    for (int i = 0; i < ML; i++) q.push_back(8'(i * 7 + 3));
    send_frame(8'hF8, 8'(ML), q, 1'b0);
    wait_idle();

    chk("left_wr", exp_w.size(), 0);
    chk("left_err", exp_err.size(), 0);
    chk("left_ok", exp_ok, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=done");
    $fatal(1);
  end

endmodule
